// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW hazard detection and stall/freeze control for a 5-stage pipeline
module hazard_ctrl #(
   parameter bit WB_BYPASS = 1'b0,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs_addr,
   input  logic [4:0]       id_rt_addr,
   input  logic             id_rs_used,
   input  logic             id_rt_used,
   input  logic             id_we,
   input  logic [4:0]       id_wr_addr,
   input  logic             ext_stall_req,
   output logic             pc_pause,
   output logic             ifid_pause,
   output logic             idexe_bubble,
   output logic             pipe_freeze,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt
);
   typedef enum logic [1:0] {RUN = 2'd0, HAZ = 2'd1, HOLD = 2'd2} state_t;
   state_t st;
   logic [5:0] trk_exe, trk_mem, trk_wb;
   logic raw_haz;
   function automatic logic hit(input logic [5:0] e, input logic [4:0] a);
      return e[5] && e[4:0] == a;
   endfunction
   function automatic logic src_haz(input logic u, input logic [4:0] a,
                                    input logic [5:0] e0, input logic [5:0] e1, input logic [5:0] e2);
      return u && a != 5'd0 && (hit(e0, a) || hit(e1, a) || (!WB_BYPASS && hit(e2, a)));
   endfunction
   assign state = st;
   // hazard detection and stall/freeze outputs, forced low while in reset
   always_comb begin
      raw_haz      = id_valid && (src_haz(id_rs_used, id_rs_addr, trk_exe, trk_mem, trk_wb) ||
                                  src_haz(id_rt_used, id_rt_addr, trk_exe, trk_mem, trk_wb));
      pc_pause     = rst && (ext_stall_req || raw_haz);
      ifid_pause   = pc_pause;
      pipe_freeze  = rst && ext_stall_req;
      idexe_bubble = rst && !ext_stall_req && raw_haz;
   end
   // tracking pipe, FSM state and saturating stall counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         trk_exe   <= 6'd0;
         trk_mem   <= 6'd0;
         trk_wb    <= 6'd0;
         st        <= RUN;
         stall_cnt <= '0;
      end else begin
         if (!ext_stall_req) begin
            trk_wb  <= trk_mem;
            trk_mem <= trk_exe;
            trk_exe <= raw_haz ? 6'd0 : {id_we && id_valid, id_wr_addr};
         end
         st <= ext_stall_req ? HOLD : raw_haz ? HAZ : RUN;
         if (pc_pause && !(&stall_cnt)) stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: random and directed checks of hazard_ctrl against a history-queue model
module tb_hazard_ctrl;
   logic clk = 1'b0, rst = 1'b0, v = 1'b0, rsu = 1'b0, rtu = 1'b0, we = 1'b0, ext = 1'b0;
   logic [4:0] rs = 5'd0, rt = 5'd0, wd = 5'd0;
   logic pc0, ifid0, bub0, frz0, pc1, ifid1, bub1, frz1;
   logic [1:0] st0, st1;
   logic [31:0] cnt0;
   logic [3:0] cnt1;
   int checks = 0, errors = 0;
   typedef logic [4:0] q_t[$];
   q_t h0, h1;
   longint mst0 = 0, mst1 = 0, mcnt0 = 0, mcnt1 = 0;
   logic lp0, lp1;
   int n0, n1;
   longint b0;

   always #5 clk = ~clk;

   hazard_ctrl #(.WB_BYPASS(1'b0), .CNT_W(32)) u0 (
      .clk(clk), .rst(rst), .id_valid(v), .id_rs_addr(rs), .id_rt_addr(rt),
      .id_rs_used(rsu), .id_rt_used(rtu), .id_we(we), .id_wr_addr(wd), .ext_stall_req(ext),
      .pc_pause(pc0), .ifid_pause(ifid0), .idexe_bubble(bub0), .pipe_freeze(frz0),
      .state(st0), .stall_cnt(cnt0));

   hazard_ctrl #(.WB_BYPASS(1'b1), .CNT_W(4)) u1 (
      .clk(clk), .rst(rst), .id_valid(v), .id_rs_addr(rs), .id_rt_addr(rt),
      .id_rs_used(rsu), .id_rt_used(rtu), .id_we(we), .id_wr_addr(wd), .ext_stall_req(ext),
      .pc_pause(pc1), .ifid_pause(ifid1), .idexe_bubble(bub1), .pipe_freeze(frz1),
      .state(st1), .stall_cnt(cnt1));

   task automatic chk(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // a source hazards if it names a non-zero register written by one of the last `depth` issued slots
   function automatic bit mhaz(input q_t h, input int depth);
      if (!v) return 1'b0;
      for (int i = 0; i < depth && i < h.size(); i++)
         if (h[i] != 5'd0 && ((rsu && rs == h[i]) || (rtu && rt == h[i]))) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      h0.delete(); h1.delete();
      mst0 = 0; mst1 = 0; mcnt0 = 0; mcnt1 = 0;
   endtask

   task automatic cyc(input logic iv, input logic [4:0] ia, input logic [4:0] ib, input logic iua,
                      input logic iub, input logic iwe, input logic [4:0] iwd, input logic iext);
      logic hz0, hz1;
      logic [4:0] d;
      v = iv; rs = ia; rt = ib; rsu = iua; rtu = iub; we = iwe; wd = iwd; ext = iext;
      #2;
      hz0 = mhaz(h0, 3);
      hz1 = mhaz(h1, 2);
      lp0 = pc0; lp1 = pc1;
      chk("pc0", 64'(pc0), 64'(ext || hz0));
      chk("ifid0", 64'(ifid0), 64'(ext || hz0));
      chk("bub0", 64'(bub0), 64'(!ext && hz0));
      chk("frz0", 64'(frz0), 64'(ext));
      chk("pc1", 64'(pc1), 64'(ext || hz1));
      chk("ifid1", 64'(ifid1), 64'(ext || hz1));
      chk("bub1", 64'(bub1), 64'(!ext && hz1));
      chk("frz1", 64'(frz1), 64'(ext));
      @(posedge clk);
      #1;
      d = (v && we) ? wd : 5'd0;
      if (!ext) begin
         h0.push_front(hz0 ? 5'd0 : d);
         h1.push_front(hz1 ? 5'd0 : d);
         if (h0.size() > 3) void'(h0.pop_back());
         if (h1.size() > 3) void'(h1.pop_back());
      end
      mst0 = ext ? 2 : (hz0 ? 1 : 0);
      mst1 = ext ? 2 : (hz1 ? 1 : 0);
      if ((ext || hz0) && mcnt0 != 64'hFFFF_FFFF) mcnt0++;
      if ((ext || hz1) && mcnt1 != 15) mcnt1++;
      chk("st0", 64'(st0), mst0);
      chk("cnt0", 64'(cnt0), mcnt0);
      chk("st1", 64'(st1), mst1);
      chk("cnt1", 64'(cnt1), mcnt1);
   endtask

   task automatic nop();
      cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
   endtask

   task automatic ins(input logic [4:0] a, input logic [4:0] b, input logic [4:0] dst, input logic e);
      cyc(1'b1, a, b, 1'b1, 1'b1, 1'b1, dst, e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      ext = 1'b1; v = 1'b1; rs = 5'd1; rsu = 1'b1;
      #3;
      chk("rst_pc0", 64'(pc0), 0);
      chk("rst_frz0", 64'(frz0), 0);
      chk("rst_bub1", 64'(bub1), 0);
      chk("rst_st0", 64'(st0), 0);
      chk("rst_cnt0", 64'(cnt0), 0);
      chk("rst_cnt1", 64'(cnt1), 0);
      @(negedge clk);
      ext = 1'b0; v = 1'b0; rst = 1'b1;
      @(posedge clk);
      #1;
      // add $3,$1,$2 then sub $4,$3,$1 held in ID
      ins(5'd1, 5'd2, 5'd3, 1'b0);
      n0 = 0; n1 = 0;
      for (int k = 0; k < 4; k++) begin
         ins(5'd3, 5'd1, 5'd4, 1'b0);
         n0 += int'(lp0); n1 += int'(lp1);
      end
      chk("raw_n0", n0, 3);
      chk("raw_n1", n1, 2);
      chk("raw_cnt0", 64'(cnt0), 3);
      chk("raw_cnt1", 64'(cnt1), 2);
      chk("raw_st0_end", 64'(st0), 0);
      repeat (3) nop();
      // one independent instruction between producer and consumer
      ins(5'd1, 5'd2, 5'd3, 1'b0);
      ins(5'd6, 5'd7, 5'd5, 1'b0);
      n0 = 0; n1 = 0;
      for (int k = 0; k < 3; k++) begin
         ins(5'd3, 5'd1, 5'd4, 1'b0);
         n0 += int'(lp0); n1 += int'(lp1);
      end
      chk("gap_n0", n0, 2);
      chk("gap_n1", n1, 1);
      repeat (3) nop();
      // register 0, invalid ID, unused operand
      ins(5'd1, 5'd2, 5'd0, 1'b0);
      ins(5'd0, 5'd0, 5'd4, 1'b0);
      chk("r0_nostall", 64'(lp0), 0);
      ins(5'd1, 5'd2, 5'd3, 1'b0);
      cyc(1'b0, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0);
      chk("inv_nostall", 64'(lp0), 0);
      cyc(1'b1, 5'd3, 5'd3, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0);
      chk("unused_nostall", 64'(lp0), 0);
      repeat (3) nop();
      // external freeze in the middle of a RAW stall
      ins(5'd1, 5'd2, 5'd3, 1'b0);
      b0 = longint'(cnt0);
      n0 = 0; n1 = 0;
      for (int k = 0; k < 8; k++) begin
         ins(5'd3, 5'd1, 5'd4, k >= 1 && k <= 4);
         n0 += int'(lp0); n1 += int'(lp1);
         if (k == 2) chk("hold_st0", 64'(st0), 2);
      end
      chk("frz_n0", n0, 7);
      chk("frz_n1", n1, 6);
      chk("frz_cnt0", longint'(cnt0) - b0, 7);
      repeat (3) nop();
      // drive the 4-bit counter into saturation
      repeat (20) cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
      chk("sat1", 64'(cnt1), 15);
      repeat (3) cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
      chk("sat1_hold", 64'(cnt1), 15);
      repeat (3) nop();
      // asynchronous reset in the middle of a RAW stall
      ins(5'd1, 5'd2, 5'd3, 1'b0);
      ins(5'd3, 5'd1, 5'd4, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_pc0", 64'(pc0), 0);
      chk("arst_bub0", 64'(bub0), 0);
      chk("arst_pc1", 64'(pc1), 0);
      chk("arst_st0", 64'(st0), 0);
      chk("arst_cnt0", 64'(cnt0), 0);
      chk("arst_cnt1", 64'(cnt1), 0);
      model_reset();
      v = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      ins(5'd3, 5'd1, 5'd4, 1'b0);
      chk("post_rst_nostall", 64'(lp0), 0);
      // random traffic on a small register set to provoke frequent hazards
      for (int k = 0; k < 400; k++)
         cyc(1'(($urandom % 8) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 5'($urandom_range(0, 3)),
             1'(($urandom % 10) == 0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
